sprite_draw: RTL and testbench
==============================

Name: sprite_draw

Overview:
- Parametrised rectangle/sprite rasteriser for the VGA pixel-write path. Successor to the single-pixel ball drawer.
- Accepts an origin, width, height, colour and mode on a go/busy/done handshake. Emits one pixel write per cycle, scanning row-major, with screen-edge clipping.
- Sits between the game-object controllers (ball, paddle, bricks) and the VGA adapter write port.

Parameters:
- COORD_W, 10, width of x/y coordinates
- SIZE_W, 6, width of w_in/h_in; max extent 2^SIZE_W-1
- COLOUR_W, 3, pixel colour width
- SCREEN_W, 160, pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, pixels with y >= SCREEN_H are clipped
- BG_COLOUR, 3'b000, colour driven in erase mode

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  request; sampled only in IDLE
- x_in  in  COORD_W  top-left x
- y_in  in  COORD_W  top-left y
- w_in  in  SIZE_W  width in pixels
- h_in  in  SIZE_W  height in pixels
- colour_in  in  COLOUR_W  fill colour
- mode  in  2  00 fill, 01 outline, 10 erase, 11 treated as fill
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle completion pulse
- writeEn  out  1  pixel write strobe
- x_out  out  COORD_W  pixel x
- y_out  out  COORD_W  pixel y
- colour  out  COLOUR_W  pixel colour

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: state IDLE; busy, done and writeEn are 0; x_out, y_out, colour and the counters cx/cy are 0.
- States:
  - IDLE -> SCAN on go.
  - SCAN -> FLUSH after the last pixel is issued.
  - FLUSH -> IDLE, with done=1 for that one cycle.
- Acceptance: go=1 at edge E0 in IDLE latches x_in, y_in, w_in, h_in, colour_in and mode. busy=1 from E0.
- Zero-size request: if w_in==0 or h_in==0, skip SCAN and go to FLUSH. No writeEn is issued; done pulses after E1.
- Scan order: counters cx (0..w-1) and cy (0..h-1), row-major. cx wraps to 0 and cy increments when cx==w-1.
- Registered outputs: the pixel for counter state k appears on the outputs after edge E(k+1).
  - x_out = x+cx, y_out = y+cy.
  - Sums are computed at COORD_W+1 bits; any sum >= 2^COORD_W is treated as off-screen.
- Pixel write gating: writeEn=1 only if the pixel is on-screen (x+cx < SCREEN_W and y+cy < SCREEN_H), and:
  - in outline mode, the pixel must be on the border: cx==0, cx==w-1, cy==0 or cy==h-1.
  - in fill and erase modes, every pixel in the rectangle qualifies.
- Skipped pixels still consume one cycle; x_out/y_out still update and writeEn=0.
- Colour: colour = BG_COLOUR in erase mode, otherwise the latched colour.
- Timing: a request of w*h pixels, w,h>0, finishes in exactly w*h+1 cycles after E0.
  - writeEn is last possibly high after E(w*h).
  - done=1 and busy=0 after E(w*h+1).
- go handling: go while busy is ignored, with no queueing. Back-to-back is allowed: go held high in the cycle done=1 is accepted at the next edge.
- Input changes: changes to inputs after acceptance have no effect.
- Reset mid-scan: the next edge forces IDLE and zeroes all outputs. No further writes and no done pulse.
- Degenerate outline shapes: w==1 or h==1 in outline mode writes every pixel, since all pixels are border pixels.

Decomposition:
- Package draw_pkg holds:
  - mode constants MODE_FILL, MODE_OUTLINE, MODE_ERASE.
  - state encodings S_IDLE, S_SCAN, S_FLUSH.
- One sub-module, sprite_scan: the cx/cy counter pair, with inputs ld, inc, w, h and outputs cx, cy, last. It is reused later by the brick-row drawer.
- The top level holds the FSM, clip/outline gating and the output registers.

Test Plan:
- Fill 2x2 at (10,20), colour 3'b010: writes at (10,20),(11,20),(10,21),(11,21) after E1..E4; done after E5; colour=010 throughout.
- Outline 3x3 at (0,0): 9 scan cycles; writeEn=0 only for (1,1); 8 writes; done after E10.
- Clipping: fill 4x2 at (158,119): writes only (158,119),(159,119); the other 6 cycles have writeEn=0; done after E9.
- Zero size (w=0, h=5): no writeEn; done after E1; busy high for exactly 1 cycle.
- go pulses during busy are ignored. With go held high, request 2 is accepted the edge after done, and its first pixel follows one cycle later.
- Reset asserted after E3 of a 4x4 fill: the next edge gives writeEn=0, busy=0 and no done. A fresh go restarts from (x_in,y_in).

Source files
------------

// File: rtl/draw_pkg.sv
// draw_pkg: shared mode constants and FSM state encoding for the sprite drawers
package draw_pkg;
    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_ERASE   = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;
endpackage

// File: rtl/sprite_draw_if.sv
// sprite_draw_if: request (go/origin/size/colour/mode), status (busy/done) and pixel write port
//   master: requester side, drives the request and observes status and pixel writes
//   slave:  drawer side
interface sprite_draw_if #(
    parameter int COORD_W  = 10,
    parameter int SIZE_W   = 6,
    parameter int COLOUR_W = 3
);
    logic                go;
    logic [COORD_W-1:0]  x_in;
    logic [COORD_W-1:0]  y_in;
    logic [SIZE_W-1:0]   w_in;
    logic [SIZE_W-1:0]   h_in;
    logic [COLOUR_W-1:0] colour_in;
    logic [1:0]          mode;
    logic                busy;
    logic                done;
    logic                writeEn;
    logic [COORD_W-1:0]  x_out;
    logic [COORD_W-1:0]  y_out;
    logic [COLOUR_W-1:0] colour;
    modport master (output go, x_in, y_in, w_in, h_in, colour_in, mode,
                    input busy, done, writeEn, x_out, y_out, colour);
    modport slave  (input go, x_in, y_in, w_in, h_in, colour_in, mode,
                    output busy, done, writeEn, x_out, y_out, colour);
endinterface

// File: rtl/sprite_scan.sv
// sprite_scan: row-major cx/cy counter pair over a w x h rectangle
//   ld: clear both counters; inc: advance one pixel; last: at final pixel (w-1,h-1)
module sprite_scan #(
    parameter int SIZE_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld,
    input  logic              inc,
    input  logic [SIZE_W-1:0] w,
    input  logic [SIZE_W-1:0] h,
    output logic [SIZE_W-1:0] cx,
    output logic [SIZE_W-1:0] cy,
    output logic              last
);
    logic [SIZE_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic              row_end;
    assign row_end = cx_q == w - SIZE_W'(1);
    assign last    = row_end && cy_q == h - SIZE_W'(1);
    assign cx      = cx_q;
    assign cy      = cy_q;
    always_comb begin
        cx_d = ld ? '0 : inc ? (row_end ? '0 : cx_q + SIZE_W'(1)) : cx_q;
        cy_d = ld ? '0 : (inc && row_end) ? cy_q + SIZE_W'(1) : cy_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end
endmodule

// File: rtl/sprite_draw.sv
// sprite_draw: clipped rectangle/outline/erase rasteriser, one registered pixel write per cycle
//   clk, reset: clock and synchronous active-high reset
//   bus (slave): go/x_in/y_in/w_in/h_in/colour_in/mode in; busy/done/writeEn/x_out/y_out/colour out
module sprite_draw
    import draw_pkg::*;
#(
    parameter int                  COORD_W   = 10,
    parameter int                  SIZE_W    = 6,
    parameter int                  COLOUR_W  = 3,
    parameter int                  SCREEN_W  = 160,
    parameter int                  SCREEN_H  = 120,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input logic          clk,
    input logic          reset,
    sprite_draw_if.slave bus
);
    state_t              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, x_out_q, x_out_d, y_out_q, y_out_d;
    logic [SIZE_W-1:0]   w_q, w_d, h_q, h_d;
    logic [COLOUR_W-1:0] col_q, col_d, colour_q, colour_d;
    logic [1:0]          mode_q, mode_d;
    logic                busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic [SIZE_W-1:0]   cx, cy;
    logic                last, accept, scan, on_screen, border;
    logic [COORD_W:0]    sx, sy;

    sprite_scan #(.SIZE_W(SIZE_W)) u_scan (
        .clk(clk), .reset(reset), .ld(accept), .inc(scan),
        .w(w_q), .h(h_q), .cx(cx), .cy(cy), .last(last)
    );

    assign accept = state_q == S_IDLE && bus.go;
    assign scan   = state_q == S_SCAN;
    // one extra bit so a sum past the coordinate range is seen as off-screen, not wrapped
    assign sx = {1'b0, x_q} + (COORD_W+1)'(cx);
    assign sy = {1'b0, y_q} + (COORD_W+1)'(cy);
    assign on_screen = !sx[COORD_W] && !sy[COORD_W] &&
                       sx < (COORD_W+1)'(SCREEN_W) && sy < (COORD_W+1)'(SCREEN_H);
    assign border = cx == '0 || cx == w_q - SIZE_W'(1) || cy == '0 || cy == h_q - SIZE_W'(1);

    always_comb begin
        state_d  = accept ? ((bus.w_in == '0 || bus.h_in == '0) ? S_FLUSH : S_SCAN)
                 : scan ? (last ? S_FLUSH : S_SCAN)
                 : state_q == S_FLUSH ? S_IDLE : state_q;
        x_d      = accept ? bus.x_in : x_q;
        y_d      = accept ? bus.y_in : y_q;
        w_d      = accept ? bus.w_in : w_q;
        h_d      = accept ? bus.h_in : h_q;
        col_d    = accept ? bus.colour_in : col_q;
        mode_d   = accept ? bus.mode : mode_q;
        busy_d   = state_q == S_IDLE ? bus.go : scan;
        done_d   = state_q == S_FLUSH;
        we_d     = scan && on_screen && (mode_q != MODE_OUTLINE || border);
        x_out_d  = scan ? sx[COORD_W-1:0] : x_out_q;
        y_out_d  = scan ? sy[COORD_W-1:0] : y_out_q;
        colour_d = scan ? (mode_q == MODE_ERASE ? BG_COLOUR : col_q) : colour_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            mode_q   <= MODE_FILL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            colour_q <= colour_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.writeEn = we_q;
    assign bus.x_out   = x_out_q;
    assign bus.y_out   = y_out_q;
    assign bus.colour  = colour_q;
endmodule

// File: tb/tb_sprite_draw.sv
// tb_sprite_draw: directed requests with a write scoreboard checked by an independent monitor
module tb_sprite_draw;
    typedef struct {int x; int y; int c; int t;} px_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    px_t  exp_q[$];

    sprite_draw_if bus();
    sprite_draw dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // reference model: expected writes of a request accepted at edge e0
    function automatic void push_px(input int x, y, w, h, c, m, e0);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                int sx = x + i;
                int sy = y + j;
                bit bord = (i == 0) || (i == w - 1) || (j == 0) || (j == h - 1);
                if (sx < 160 && sy < 120 && (m != 1 || bord))
                    exp_q.push_back('{sx, sy, (m == 2) ? 0 : c, e0 + j * w + i + 1});
            end
    endfunction

    always @(negedge clk) begin
        if (bus.writeEn) begin
            px_t e;
            wr_cnt++;
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_x", int'(bus.x_out), e.x);
                chk("wr_y", int'(bus.y_out), e.y);
                chk("wr_colour", int'(bus.colour), e.c);
                chk("wr_cycle", cyc, e.t);
            end
        end
    end

    task automatic set_req(input int x, y, w, h, c, m);
        bus.x_in = 10'(x);
        bus.y_in = 10'(y);
        bus.w_in = 6'(w);
        bus.h_in = 6'(h);
        bus.colour_in = 3'(c);
        bus.mode = 2'(m);
    endtask

    task automatic wait_done(input int e0, input int exp);
        int n = 0;
        while (!bus.done && n < 2000) begin
            chk("busy_before_done", int'(bus.busy), 1);
            step();
            n++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
        else begin
            chk("done_cycle", cyc - e0, exp);
            chk("busy_at_done", int'(bus.busy), 0);
        end
        step();
        chk("done_one_pulse", int'(bus.done), 0);
    endtask

    task automatic run(input int x, y, w, h, c, m, exp_cyc, exp_wr, input bit glitch);
        int e0, wr0;
        step();
        wr0 = wr_cnt;
        e0 = cyc + 1;
        push_px(x, y, w, h, c, m, e0);
        set_req(x, y, w, h, c, m);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        set_req(x + 7, y + 3, w + 1, h + 1, c ^ 7, m ^ 1);
        if (glitch) begin
            bus.go = 1'b1;
            bus.x_in = 10'd99;
            step();
            bus.go = 1'b0;
        end
        wait_done(e0, exp_cyc);
        chk("write_count", wr_cnt - wr0, exp_wr);
    endtask

    initial begin
        int e0, wr0;
        bus.go = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_we", int'(bus.writeEn), 0);
        chk("rst_x", int'(bus.x_out), 0);
        chk("rst_y", int'(bus.y_out), 0);
        chk("rst_colour", int'(bus.colour), 0);
        reset = 1'b0;
        run(10, 20, 2, 2, 3'b010, 0, 5, 4, 1);
        run(0, 0, 3, 3, 3'b101, 1, 10, 8, 1);
        run(158, 119, 4, 2, 3'b111, 0, 9, 2, 0);
        run(40, 50, 0, 5, 3'b011, 0, 1, 0, 0);
        run(50, 60, 2, 1, 3'b110, 2, 3, 2, 0);
        run(20, 30, 1, 3, 3'b100, 1, 4, 3, 0);
        run(1020, 5, 6, 1, 3'b001, 3, 7, 0, 0);
        // back-to-back: go held high through done
        step();
        wr0 = wr_cnt;
        e0 = cyc + 1;
        push_px(5, 5, 2, 1, 3, 0, e0);
        push_px(70, 80, 1, 2, 4, 2, e0 + 4);
        set_req(5, 5, 2, 1, 3, 0);
        bus.go = 1'b1;
        step();
        set_req(70, 80, 1, 2, 4, 2);
        wait_done(e0, 3);
        bus.go = 1'b0;
        chk("b2b_accepted", int'(bus.busy), 1);
        wait_done(e0 + 4, 3);
        chk("b2b_write_count", wr_cnt - wr0, 4);
        // reset after E3 of a 4x4 fill
        step();
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) exp_q.push_back('{30 + k, 40, 5, e0 + k + 1});
        set_req(30, 40, 4, 4, 5, 0);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("mid_rst_we", int'(bus.writeEn), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_x", int'(bus.x_out), 0);
        reset = 1'b0;
        wr0 = wr_cnt;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_idle_done", int'(bus.done), 0);
        end
        chk("post_rst_no_write", wr_cnt - wr0, 0);
        run(30, 40, 1, 1, 5, 0, 2, 1, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
